// File: rtl/des_feistel_round.sv
// One DES Feistel round as a two-stage valid/ready pipeline:
// stage 1 registers E(R)^K, stage 2 registers the S-box/P result XOR L with the half swap.

module des_sbox #(
    parameter logic [255:0] TABLE = 256'h0
) (
    input  logic [5:0] din,
    output logic [3:0] dout
);
    logic [5:0] idx_s;

    // Row is the outer bit pair, column the inner four bits; entry 0 sits at the table MSB.
    always_comb begin
        idx_s = {din[5], din[0], din[4:1]};
        dout  = TABLE[8'd255 - {idx_s, 2'b00} -: 4];
    end
endmodule

module des_feistel_round #(
    parameter bit NO_SWAP = 1'b0
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] l_in,
    input  logic [31:0] r_in,
    input  logic [47:0] subkey,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] l_out,
    output logic [31:0] r_out
);
    localparam logic [255:0] SBOX_TBL [8] = '{
        256'he4d12fb83a6c5907_0f74e2d1a6cb9538_41e8d62bfc973a50_fc8249175b3ea06d,
        256'hf18e6b34972dc05a_3d47f28ec01a69b5_0e7ba4d158c6932f_d8a13f42b67c05e9,
        256'ha09e63f51dc7b428_d709346a285ecbf1_d6498f30b12c5ae7_1ad069874fe3b52c,
        256'h7de3069a1285bc4f_d8b56f03472c1ae9_a690cb7df13e5284_3f06a1d8945bc72e,
        256'h2c417ab6853fd0e9_eb2c47d150fa3986_421bad78f9c5630e_b8c71e2d6f09a453,
        256'hc1af92680d34e75b_af427c9561de0b38_9ef528c3704a1db6_432c95fabe17608d,
        256'h4b2ef08d3c975a61_d0b7491ae35c2f86_14bdc37eaf680592_6bd814a7950fe23c,
        256'hd2846fb1a93e50c7_1fd8a374c56b0e92_7b419ce206adf358_21e74a8dfc90356b
    };

    logic        s1_valid_r;
    logic [47:0] s1_x_r;
    logic [31:0] s1_l_r;
    logic [31:0] s1_r_r;
    logic        out_valid_r;
    logic [31:0] l_out_r;
    logic [31:0] r_out_r;
    logic        s2_adv_s;
    logic [47:0] e_s;
    logic [31:0] f_pre_s;
    logic [31:0] f_s;
    logic [31:0] lf_s;

    for (genvar g = 0; g < 8; g++) begin : g_sbox
        des_sbox #(.TABLE(SBOX_TBL[g])) u_sbox (
            .din  (s1_x_r[47-6*g -: 6]),
            .dout (f_pre_s[31-4*g -: 4])
        );
    end

    // Ready chain depends only on registered state and out_ready; E and P are pure wiring (DES bit n = [32-n]).
    always_comb begin
        s2_adv_s = ~out_valid_r | out_ready;
        in_ready = ~s1_valid_r | s2_adv_s;
        e_s = {r_in[0], r_in[31:27], r_in[28:23], r_in[24:19], r_in[20:15],
               r_in[16:11], r_in[12:7], r_in[8:3], r_in[4:0], r_in[31]};
        f_s = {f_pre_s[16], f_pre_s[25], f_pre_s[12], f_pre_s[11],
               f_pre_s[3],  f_pre_s[20], f_pre_s[4],  f_pre_s[15],
               f_pre_s[31], f_pre_s[17], f_pre_s[9],  f_pre_s[6],
               f_pre_s[27], f_pre_s[14], f_pre_s[1],  f_pre_s[22],
               f_pre_s[30], f_pre_s[24], f_pre_s[8],  f_pre_s[18],
               f_pre_s[0],  f_pre_s[5],  f_pre_s[29], f_pre_s[23],
               f_pre_s[13], f_pre_s[19], f_pre_s[2],  f_pre_s[26],
               f_pre_s[10], f_pre_s[21], f_pre_s[28], f_pre_s[7]};
        lf_s = s1_l_r ^ f_s;
    end

    // Valid bits of both stages.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_valid_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid_r <= in_valid;
            end
            if (s2_adv_s) begin
                out_valid_r <= s1_valid_r;
            end
        end
    end

    // Stage 1 data: subkey is consumed here and not needed afterwards.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_x_r <= 48'h0;
            s1_l_r <= 32'h0;
            s1_r_r <= 32'h0;
        end else if (in_ready && in_valid) begin
            s1_x_r <= e_s ^ subkey;
            s1_l_r <= l_in;
            s1_r_r <= r_in;
        end
    end

    // Stage 2 data: round 16 skips the half swap.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            l_out_r <= 32'h0;
            r_out_r <= 32'h0;
        end else if (s2_adv_s && s1_valid_r) begin
            l_out_r <= NO_SWAP ? lf_s : s1_r_r;
            r_out_r <= NO_SWAP ? s1_r_r : lf_s;
        end
    end

    assign out_valid = out_valid_r;
    assign l_out     = l_out_r;
    assign r_out     = r_out_r;
endmodule

// File: tb/tb_des_feistel_round.sv
// Scoreboard bench for des_feistel_round: both NO_SWAP variants run side by side on one stimulus,
// expected values come from a table-driven DES f model.

module tb_des_feistel_round;
    localparam int E_TBL [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9,
                                   8, 9,10,11,12,13,12,13,14,15,16,17,
                                  16,17,18,19,20,21,20,21,22,23,24,25,
                                  24,25,26,27,28,29,28,29,30,31,32, 1};
    localparam int P_TBL [32] = '{16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10,
                                   2, 8,24,14,32,27, 3, 9,19,13,30, 6,22,11, 4,25};
    localparam logic [255:0] SBOX_TBL [8] = '{
        256'he4d12fb83a6c5907_0f74e2d1a6cb9538_41e8d62bfc973a50_fc8249175b3ea06d,
        256'hf18e6b34972dc05a_3d47f28ec01a69b5_0e7ba4d158c6932f_d8a13f42b67c05e9,
        256'ha09e63f51dc7b428_d709346a285ecbf1_d6498f30b12c5ae7_1ad069874fe3b52c,
        256'h7de3069a1285bc4f_d8b56f03472c1ae9_a690cb7df13e5284_3f06a1d8945bc72e,
        256'h2c417ab6853fd0e9_eb2c47d150fa3986_421bad78f9c5630e_b8c71e2d6f09a453,
        256'hc1af92680d34e75b_af427c9561de0b38_9ef528c3704a1db6_432c95fabe17608d,
        256'h4b2ef08d3c975a61_d0b7491ae35c2f86_14bdc37eaf680592_6bd814a7950fe23c,
        256'hd2846fb1a93e50c7_1fd8a374c56b0e92_7b419ce206adf358_21e74a8dfc90356b
    };

    logic        clk = 1'b0;
    logic        n_rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] l_in = 32'h0;
    logic [31:0] r_in = 32'h0;
    logic [47:0] subkey = 48'h0;
    logic        in_ready0, in_ready1, out_valid0, out_valid1;
    logic [31:0] l_out0, r_out0, l_out1, r_out1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int accepted = 0;
    int emitted = 0;
    int first_emit = -1;
    int last_emit = -1;
    logic [63:0] sb [$];
    logic [31:0] hold_l, hold_r;
    int a0, e0;

    des_feistel_round #(.NO_SWAP(1'b0)) dut0 (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready0),
        .l_in(l_in), .r_in(r_in), .subkey(subkey), .out_valid(out_valid0),
        .out_ready(out_ready), .l_out(l_out0), .r_out(r_out0));

    des_feistel_round #(.NO_SWAP(1'b1)) dut1 (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready1),
        .l_in(l_in), .r_in(r_in), .subkey(subkey), .out_valid(out_valid1),
        .out_ready(out_ready), .l_out(l_out1), .r_out(r_out1));

    always #5 clk = ~clk;

    function automatic logic [31:0] model_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0]  x;
        logic [31:0]  pre;
        logic [31:0]  f;
        logic [5:0]   six;
        logic [255:0] t;
        int           idx;
        for (int i = 0; i < 48; i++) x[47-i] = r[32-E_TBL[i]];
        x = x ^ k;
        for (int b = 0; b < 8; b++) begin
            six = x[47-6*b -: 6];
            idx = int'({six[5], six[0]}) * 16 + int'(six[4:1]);
            t = SBOX_TBL[b];
            pre[31-4*b -: 4] = t[255-4*idx -: 4];
        end
        for (int i = 0; i < 32; i++) f[31-i] = pre[32-P_TBL[i]];
        return f;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes on the falling edge, score the emit, queue the accept.
    task automatic tick();
        logic [63:0] exp;
        @(negedge clk);
        if (out_valid0 && out_ready) begin
            emitted++;
            if (first_emit < 0) first_emit = cyc;
            last_emit = cyc;
            check("sb_has_entry", {63'd0, sb.size() != 0}, 64'd1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                check("out0", {l_out0, r_out0}, exp);
                check("out1", {out_valid1, l_out1, r_out1}, {1'b1, exp[31:0], exp[63:32]});
            end
        end
        if (in_valid && in_ready0) begin
            accepted++;
            sb.push_back({r_in, l_in ^ model_f(r_in, subkey)});
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand();
        l_in   = $urandom;
        r_in   = $urandom;
        subkey = {16'($urandom), 32'($urandom)};
    endtask

    initial begin
        // Reset state
        #2 n_rst = 1'b0;
        #1;
        check("rst_out_valid", {62'd0, out_valid0, out_valid1}, 64'd0);
        check("rst_in_ready", {62'd0, in_ready0, in_ready1}, 64'd3);
        tick();
        tick();
        n_rst = 1'b1;
        check("rst_regs_zero", {l_out0, r_out0}, 64'd0);

        // Known vector and latency
        check("model_vector", {32'd0, model_f(32'hF0AAF0AA, 48'h1B02EFFC7072)}, 64'h234AA9BB);
        l_in = 32'hCC00CCFF; r_in = 32'hF0AAF0AA; subkey = 48'h1B02EFFC7072;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; subkey = 48'hFFFFFFFFFFFF;
        check("lat_not_yet", {63'd0, out_valid0}, 64'd0);
        tick();
        check("lat_valid", {62'd0, out_valid0, out_valid1}, 64'd3);
        check("kv_swap", {l_out0, r_out0}, 64'hF0AAF0AA_EF4A6544);
        check("kv_noswap", {l_out1, r_out1}, 64'hEF4A6544_F0AAF0AA);
        tick();
        tick();

        // Eight back-to-back transfers
        a0 = accepted; e0 = emitted; first_emit = -1;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_rand();
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("stream_accepts", 64'(accepted - a0), 64'd8);
        check("stream_emits", 64'(emitted - e0), 64'd8);
        check("stream_contig", 64'(last_emit - first_emit), 64'd7);

        // Backpressure from an empty pipe
        a0 = accepted; e0 = emitted;
        out_ready = 1'b0; in_valid = 1'b1;
        drive_rand(); tick();
        drive_rand(); tick();
        hold_l = l_out0; hold_r = r_out0;
        for (int i = 0; i < 3; i++) begin
            drive_rand(); tick();
            check("stall_hold", {out_valid0, l_out0, r_out0}, {1'b1, hold_l, hold_r});
        end
        check("stall_accepts", 64'(accepted - a0), 64'd2);
        check("stall_in_ready", {62'd0, in_ready0, in_ready1}, 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_rand(); tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("stall_drained", 64'(sb.size()), 64'd0);
        check("stall_no_loss", 64'(emitted - e0), 64'(accepted - a0));

        // Asynchronous reset with both stages full
        out_ready = 1'b0; in_valid = 1'b1;
        drive_rand(); tick();
        drive_rand(); tick();
        in_valid = 1'b0;
        check("full_before_rst", {62'd0, out_valid0, in_ready0}, 64'd2);
        #2 n_rst = 1'b0;
        #1;
        check("async_rst_valid", {62'd0, out_valid0, out_valid1}, 64'd0);
        sb.delete();
        tick();
        tick();
        n_rst = 1'b1;
        check("post_rst_ready", {62'd0, in_ready0, out_valid0}, 64'd2);
        e0 = emitted;
        out_ready = 1'b1; in_valid = 1'b1;
        drive_rand(); tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("post_rst_one_out", 64'(emitted - e0), 64'd1);
        check("post_rst_drained", 64'(sb.size()), 64'd0);

        // Random traffic
        a0 = accepted;
        for (int c = 0; c < 20000 && (accepted - a0) < 1000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            drive_rand();
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("rand_accepts", 64'(accepted - a0), 64'd1000);
        check("rand_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
